// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_pkg
// Purpose  : Shared state encodings and handshake constants for the
//            iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

  // Divider controller states (2-bit encoding)
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Handshake levels
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration. Shifts the next
//            dividend bit into the partial remainder and subtracts the
//            divisor when it fits.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              msb_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_dvs_ext;

  // Trial subtraction is done one bit wider than the operands: the shifted
  // remainder can reach 2*divisor-1, which may not fit in DATA_W bits.
  always_comb begin
    w_shift   = {rem_i, msb_i};
    w_dvs_ext = {1'b0, divisor_i};
    q_bit_o   = (w_shift >= w_dvs_ext);
    rem_o     = q_bit_o ? DATA_W'(w_shift - w_dvs_ext) : w_shift[DATA_W-1:0];
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Sequential radix-2 restoring divider (signed/unsigned) for the
//            EX stage. Returns {remainder, quotient} for HI/LO writeback.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
  logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend shifting out, quotient in
  logic [DATA_W-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   w_rem_next;
  logic                w_q_bit;
  logic [DATA_W-1:0]   w_quo_next;
  logic                w_a_neg, w_b_neg;
  logic [DATA_W-1:0]   w_a_mag, w_b_mag;
  logic [DATA_W-1:0]   w_quo_fix, w_rem_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[DATA_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (w_rem_next),
    .q_bit_o   (w_q_bit)
  );

  // Operand magnitudes and sign-corrected final result
  always_comb begin
    w_a_neg    = signed_div_i & opdata1_i[DATA_W-1];
    w_b_neg    = signed_div_i & opdata2_i[DATA_W-1];
    w_a_mag    = w_a_neg ? -opdata1_i : opdata1_i;
    w_b_mag    = w_b_neg ? -opdata2_i : opdata2_i;
    w_quo_next = {dvd_q[DATA_W-2:0], w_q_bit};
    w_quo_fix  = q_neg_q ? -w_quo_next : w_quo_next;
    w_rem_fix  = r_neg_q ? -w_rem_next : w_rem_next;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = w_a_mag;
            dvs_d   = w_b_mag;
            q_neg_d = w_a_neg ^ w_b_neg;
            r_neg_d = w_a_neg;
          end
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else begin
          rem_d = w_rem_next;
          dvd_d = w_quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            result_d = {w_rem_fix, w_quo_fix};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule : div_iter
`default_nettype wire
